lc4_branch_resolve: RTL and testbench
=====================================

# lc4_branch_resolve

Consumer side of the LC4 compare path: converts 16-bit result values (CMP/CMPU/CMPI/CMPUI outputs of -1/0/+1, or any register write-back value) into the NZP condition-code register and resolves BR instructions against it. It sits after ALU write-back and before fetch. It holds NZP state, produces a registered redirect one cycle after a branch is accepted, and sequences a two-cycle flush window after every taken branch.

## Interface
Parameters:
- FLUSH_CYCLES, 2, number of cycles `flush` stays high after a taken redirect (1..3)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- gwe  in  1  global write enable; when 0, all state holds and outputs keep their values
- nzp_we  in  1  update NZP from `nzp_val` this cycle
- nzp_val  in  16  write-back value (two's complement)
- br_valid  in  1  branch request present
- br_ready  out  1  branch request accepted when `br_valid & br_ready & gwe`
- br_mask  in  3  {n,z,p} test bits (instr[11:9])
- br_pc  in  16  PC+1 of the branch
- br_imm9  in  9  signed offset (instr[8:0])
- rdr_valid  out  1  one-cycle pulse: branch resolved
- rdr_taken  out  1  resolved branch is taken (valid with `rdr_valid`)
- rdr_target  out  16  br_pc + sext(br_imm9), mod 2^16
- flush  out  1  squash younger fetch/decode slots
- nzp  out  3  current NZP register {N,Z,P}

## Operation
- NZP generation: N = val[15]; Z = (val == 16'h0000); P = ~N & ~Z. Exactly one bit set at all times. -1 -> 100, 0 -> 010, +1 -> 001, 16'h8000 -> 100, 16'h7FFF -> 001.
- Branch evaluation: taken = |(br_mask & nzp_eff). Mask 000 never taken (NOP); mask 111 always taken.
- Target arithmetic: 9-bit signed extend to 16 bits, add to br_pc, discard carry (16'hFFFF + 1 -> 16'h0000; 16'h0000 + (-1) -> 16'hFFFF). Target computed even when not taken.
- FSM states: IDLE, FLUSH.
  - IDLE: br_ready = 1 (subject to Configuration). Accepted taken branch -> FLUSH, counter loaded with FLUSH_CYCLES. Accepted not-taken branch stays IDLE.
  - FLUSH: br_ready = 0, flush = 1, counter decrements each gwe cycle; at 1 -> IDLE. Branch requests in this state are not accepted (requester holds them).
- NZP writes are honored in every state, including FLUSH (older in-flight instructions).
- Reset: nzp = 3'b010, state IDLE, counter 0, rdr_valid = 0, rdr_taken = 0, rdr_target = 0, flush = 0, br_ready = 1 from the first cycle after reset. Reset during FLUSH aborts the window immediately.

## Timing
- NZP register: written at the clock edge of the `nzp_we` cycle; visible on `nzp` the next cycle.
- Redirect latency: 1 cycle. Accept in cycle T -> rdr_valid/rdr_taken/rdr_target registered, visible in T+1 for exactly one cycle.
- flush asserted T+1 through T+FLUSH_CYCLES for a taken branch accepted at T; next branch acceptable at T+FLUSH_CYCLES+1.
- gwe = 0 in any cycle: no accept, no NZP write, counter frozen, rdr_valid held (no new pulse generated and the existing one not cleared).

## Configuration
- LC4_NZP_BYPASS_EN defined: when `nzp_we` and a branch accept coincide, nzp_eff = NZP generated from `nzp_val` this cycle (forwarded); br_ready unaffected.
- Undefined: nzp_eff = NZP register only; br_ready = 0 in IDLE whenever `nzp_we` = 1, so the branch is accepted the following cycle against the updated register (one-cycle stall).

## Structure
- Package lc4_br_pkg: state enum (IDLE, FLUSH), NZP constants NZP_N = 3'b100, NZP_Z = 3'b010, NZP_P = 3'b001, NZP reset value.
- Sub-module lc4_nzp_gen: combinational 16-bit value -> 3-bit NZP; instantiated once for the write path and reused by the bypass mux.

## Test plan
- Reset, then check outputs -> nzp = 010, br_ready = 1, flush = 0, rdr_valid = 0.
- nzp_we with 16'hFFFF, then a BRn (mask 100, pc 16'h0010, imm9 9'h1F0) -> rdr_taken = 1, rdr_target = 16'h0000, flush high 2 cycles, br_ready low 2 cycles.
- nzp_we with 16'h0001, then BRnz (mask 110) -> rdr_valid pulse, rdr_taken = 0, no flush, br_ready remains 1.
- Same-cycle nzp_we 16'h0000 and BRz (mask 010) with previous nzp = 001 -> bypass: accepted, taken; no bypass: br_ready = 0 for one cycle, then accepted and taken.
- Taken branch, then rst asserted in the first flush cycle -> flush = 0, state IDLE, and nzp = 010 the next cycle.
- Hold gwe = 0 during FLUSH for 3 cycles -> flush stays 1 and the counter stays frozen, then resumes and deasserts after the remaining cycle.

Source files
------------

// File: rtl/lc4_branch_resolve_pkg.sv
// Shared types and constants for the LC4 branch-resolve slice.
// Optional feature macro used by the top: LC4_NZP_BYPASS_EN.
package lc4_br_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } br_state_t;

  localparam logic [2:0] NZP_N   = 3'b100;
  localparam logic [2:0] NZP_Z   = 3'b010;
  localparam logic [2:0] NZP_P   = 3'b001;
  localparam logic [2:0] NZP_RST = NZP_Z;

  // Wide enough for FLUSH_CYCLES up to 3.
  localparam int CNT_W = 2;

  function automatic logic [15:0] sext9(input logic [8:0] imm);
    return {{7{imm[8]}}, imm};
  endfunction

endpackage

// File: rtl/lc4_branch_resolve_nzp_gen.sv
// Combinational 16-bit write-back value to one-hot {N,Z,P} condition code.
module lc4_nzp_gen
  import lc4_br_pkg::*;
(
  input  logic [15:0] val,
  output logic [2:0]  nzp
);

  always_comb begin
    nzp = NZP_P;
    if (val[15]) begin
      nzp = NZP_N;
    end else if (val == 16'h0000) begin
      nzp = NZP_Z;
    end
  end

endmodule

// File: rtl/lc4_branch_resolve.sv
// NZP register, BR resolution with registered redirect and post-taken flush window.
// Build option: define LC4_NZP_BYPASS_EN to forward same-cycle NZP writes to branches.
module lc4_branch_resolve
  import lc4_br_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            gwe,
  input  logic            nzp_we,
  input  logic [15:0]     nzp_val,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [2:0]      br_mask,
  input  logic [15:0]     br_pc,
  input  logic [8:0]      br_imm9,
  output logic            rdr_valid,
  output logic            rdr_taken,
  output logic [15:0]     rdr_target,
  output logic            flush,
  output logic [2:0]      nzp,
  output br_state_t       fsm_state
);

  // Handshake: a branch is consumed in a cycle where br_valid & br_ready & gwe;
  // the requester holds br_* stable while br_ready is low.

  br_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        nzp_q;
  logic [2:0]        nzp_wr;
  logic [2:0]        nzp_eff;
  logic              accept;
  logic              taken;
  logic [15:0]       target;
  logic              stall_on_we;

  lc4_nzp_gen u_nzp_gen (
    .val (nzp_val),
    .nzp (nzp_wr)
  );

`ifdef LC4_NZP_BYPASS_EN
  assign nzp_eff     = nzp_we ? nzp_wr : nzp_q;
  assign stall_on_we = 1'b0;
`else
  // Without forwarding, hold off the branch one cycle so it sees the new NZP.
  assign nzp_eff     = nzp_q;
  assign stall_on_we = nzp_we;
`endif

  assign br_ready  = (state_q == IDLE) && !stall_on_we;
  assign accept    = br_valid & br_ready & gwe;
  assign taken     = |(br_mask & nzp_eff);
  assign target    = br_pc + sext9(br_imm9);
  assign flush     = (state_q == FLUSH);
  assign nzp       = nzp_q;
  assign fsm_state = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && taken) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_CYCLES[CNT_W-1:0];
        end
      end
      FLUSH: begin
        if (gwe) begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nzp_q      <= NZP_RST;
      rdr_valid  <= 1'b0;
      rdr_taken  <= 1'b0;
      rdr_target <= 16'h0000;
    end else if (gwe) begin
      if (nzp_we) begin
        nzp_q <= nzp_wr;
      end
      rdr_valid <= accept;
      rdr_taken <= accept & taken;
      if (accept) begin
        rdr_target <= target;
      end
    end
  end

endmodule

// File: tb/tb_lc4_branch_resolve.sv
// Bench for lc4_branch_resolve: vector table plus hand-written reset/gwe/bypass sequences.
module tb_lc4_branch_resolve;
  import lc4_br_pkg::*;

  localparam int FC = 2;

  logic        clk;
  logic        rst;
  logic        gwe;
  logic        nzp_we;
  logic [15:0] nzp_val;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_mask;
  logic [15:0] br_pc;
  logic [8:0]  br_imm9;
  logic        rdr_valid;
  logic        rdr_taken;
  logic [15:0] rdr_target;
  logic        flush;
  logic [2:0]  nzp;
  br_state_t   fsm_state;

  lc4_branch_resolve #(.FLUSH_CYCLES(FC)) dut (
    .clk        (clk),
    .rst        (rst),
    .gwe        (gwe),
    .nzp_we     (nzp_we),
    .nzp_val    (nzp_val),
    .br_valid   (br_valid),
    .br_ready   (br_ready),
    .br_mask    (br_mask),
    .br_pc      (br_pc),
    .br_imm9    (br_imm9),
    .rdr_valid  (rdr_valid),
    .rdr_taken  (rdr_taken),
    .rdr_target (rdr_target),
    .flush      (flush),
    .nzp        (nzp),
    .fsm_state  (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    logic [2:0]  mask;
    logic [15:0] pc;
    logic [8:0]  imm;
    logic [2:0]  exp_nzp;
    logic        exp_taken;
    logic [15:0] exp_target;
  } vec_t;

  vec_t        vecs[8];
  logic [16:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic expect_rdr(input string name);
    logic [16:0] e;
    chk({name, "_rdr_valid"}, {31'b0, rdr_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_queue: got empty expected entry", name);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_rdr_taken"}, {31'b0, rdr_taken}, {31'b0, e[16]});
      chk({name, "_rdr_target"}, {16'b0, rdr_target}, {16'b0, e[15:0]});
    end
  endtask

  // Called at the sample point of the first flush cycle.
  task automatic finish_flush(input string name);
    for (int i = 1; i < FC; i++) begin
      step();
      samp();
      chk({name, "_flush_hold"}, {31'b0, flush}, 32'd1);
      chk({name, "_ready_low"}, {31'b0, br_ready}, 32'd0);
      chk({name, "_rdr_pulse"}, {31'b0, rdr_valid}, 32'd0);
    end
    step();
    samp();
    chk({name, "_flush_end"}, {31'b0, flush}, 32'd0);
    chk({name, "_ready_back"}, {31'b0, br_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    step();
    nzp_we   = 1'b1;
    nzp_val  = v.val;
    br_valid = 1'b0;
    samp();
    step();
    nzp_we   = 1'b0;
    br_valid = 1'b1;
    br_mask  = v.mask;
    br_pc    = v.pc;
    br_imm9  = v.imm;
    samp();
    chk({nm, "_nzp"}, {29'b0, nzp}, {29'b0, v.exp_nzp});
    chk({nm, "_ready"}, {31'b0, br_ready}, 32'd1);
    exp_q.push_back({v.exp_taken, v.exp_target});
    step();
    br_valid = 1'b0;
    samp();
    expect_rdr(nm);
    chk({nm, "_flush"}, {31'b0, flush}, {31'b0, v.exp_taken});
    if (v.exp_taken) begin
      finish_flush(nm);
    end else begin
      chk({nm, "_ready_nt"}, {31'b0, br_ready}, 32'd1);
      step();
      samp();
      chk({nm, "_rdr_drop"}, {31'b0, rdr_valid}, 32'd0);
      chk({nm, "_flush_nt"}, {31'b0, flush}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{16'hFFFF, 3'b100, 16'h0010, 9'h1F0, 3'b100, 1'b1, 16'h0000};
    vecs[1] = '{16'h0001, 3'b110, 16'h0020, 9'h005, 3'b001, 1'b0, 16'h0025};
    vecs[2] = '{16'h0000, 3'b010, 16'h0100, 9'h0FF, 3'b010, 1'b1, 16'h01FF};
    vecs[3] = '{16'h8000, 3'b011, 16'hFFFF, 9'h001, 3'b100, 1'b0, 16'h0000};
    vecs[4] = '{16'h7FFF, 3'b001, 16'h0000, 9'h1FF, 3'b001, 1'b1, 16'hFFFF};
    vecs[5] = '{16'h1234, 3'b000, 16'h1000, 9'h100, 3'b001, 1'b0, 16'h0F00};
    vecs[6] = '{16'hFFFE, 3'b111, 16'h2000, 9'h0AA, 3'b100, 1'b1, 16'h20AA};
    vecs[7] = '{16'h0000, 3'b101, 16'h3000, 9'h155, 3'b010, 1'b0, 16'h2F55};

    rst      = 1'b1;
    gwe      = 1'b1;
    nzp_we   = 1'b0;
    nzp_val  = 16'h0000;
    br_valid = 1'b0;
    br_mask  = 3'b000;
    br_pc    = 16'h0000;
    br_imm9  = 9'h000;
    repeat (3) step();
    rst = 1'b0;
    samp();
    chk("rst_nzp", {29'b0, nzp}, 32'h2);
    chk("rst_ready", {31'b0, br_ready}, 32'd1);
    chk("rst_flush", {31'b0, flush}, 32'd0);
    chk("rst_rdr_valid", {31'b0, rdr_valid}, 32'd0);
    chk("rst_rdr_taken", {31'b0, rdr_taken}, 32'd0);
    chk("rst_rdr_target", {16'b0, rdr_target}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
    end

    // Same-cycle NZP write and BRz, previous NZP = P.
    step();
    nzp_we  = 1'b1;
    nzp_val = 16'h0005;
    samp();
    step();
    nzp_we   = 1'b1;
    nzp_val  = 16'h0000;
    br_valid = 1'b1;
    br_mask  = 3'b010;
    br_pc    = 16'h0040;
    br_imm9  = 9'h004;
    samp();
    chk("same_prev_nzp", {29'b0, nzp}, 32'h1);
`ifdef LC4_NZP_BYPASS_EN
    chk("same_ready_byp", {31'b0, br_ready}, 32'd1);
    exp_q.push_back({1'b1, 16'h0044});
    step();
    nzp_we   = 1'b0;
    br_valid = 1'b0;
    samp();
`else
    chk("same_ready_stall", {31'b0, br_ready}, 32'd0);
    step();
    nzp_we = 1'b0;
    samp();
    chk("same_ready_retry", {31'b0, br_ready}, 32'd1);
    chk("same_nzp_upd", {29'b0, nzp}, 32'h2);
    exp_q.push_back({1'b1, 16'h0044});
    step();
    br_valid = 1'b0;
    samp();
`endif
    expect_rdr("same");
    chk("same_flush", {31'b0, flush}, 32'd1);
    chk("same_nzp", {29'b0, nzp}, 32'h2);
    finish_flush("same");

    // Reset in the first flush cycle.
    step();
    nzp_we  = 1'b1;
    nzp_val = 16'hFFFF;
    samp();
    step();
    nzp_we   = 1'b0;
    br_valid = 1'b1;
    br_mask  = 3'b100;
    br_pc    = 16'h0100;
    br_imm9  = 9'h010;
    samp();
    chk("rf_ready", {31'b0, br_ready}, 32'd1);
    exp_q.push_back({1'b1, 16'h0110});
    step();
    br_valid = 1'b0;
    samp();
    expect_rdr("rf");
    chk("rf_flush", {31'b0, flush}, 32'd1);
    chk("rf_nzp", {29'b0, nzp}, 32'h4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    samp();
    chk("rf_flush_abort", {31'b0, flush}, 32'd0);
    chk("rf_ready_after", {31'b0, br_ready}, 32'd1);
    chk("rf_nzp_reset", {29'b0, nzp}, 32'h2);
    chk("rf_state", {31'b0, fsm_state}, {31'b0, IDLE});
    chk("rf_rdr_valid", {31'b0, rdr_valid}, 32'd0);
    chk("rf_rdr_target", {16'b0, rdr_target}, 32'd0);

    // gwe held low for three cycles during the flush window.
    step();
    br_valid = 1'b1;
    br_mask  = 3'b010;
    br_pc    = 16'h0200;
    br_imm9  = 9'h1FE;
    samp();
    chk("gw_ready", {31'b0, br_ready}, 32'd1);
    exp_q.push_back({1'b1, 16'h01FE});
    step();
    br_valid = 1'b0;
    gwe      = 1'b0;
    nzp_we   = 1'b1;
    nzp_val  = 16'hFFFF;
    samp();
    expect_rdr("gw");
    chk("gw_flush0", {31'b0, flush}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      step();
      samp();
      chk("gw_flush_frozen", {31'b0, flush}, 32'd1);
      chk("gw_rdr_held", {31'b0, rdr_valid}, 32'd1);
      chk("gw_ready_low", {31'b0, br_ready}, 32'd0);
      chk("gw_nzp_held", {29'b0, nzp}, 32'h2);
    end
    step();
    gwe    = 1'b1;
    nzp_we = 1'b0;
    samp();
    chk("gw_resume_flush", {31'b0, flush}, 32'd1);
    chk("gw_resume_rdr", {31'b0, rdr_valid}, 32'd1);
    chk("gw_resume_nzp", {29'b0, nzp}, 32'h2);
    step();
    samp();
    chk("gw_last_flush", {31'b0, flush}, 32'd1);
    chk("gw_rdr_clear", {31'b0, rdr_valid}, 32'd0);
    step();
    samp();
    chk("gw_flush_end", {31'b0, flush}, 32'd0);
    chk("gw_ready_back", {31'b0, br_ready}, 32'd1);

    // gwe low in IDLE blocks acceptance of a pending branch.
    step();
    gwe      = 1'b0;
    br_valid = 1'b1;
    br_mask  = 3'b111;
    br_pc    = 16'h0300;
    br_imm9  = 9'h000;
    samp();
    step();
    samp();
    chk("gi_no_rdr", {31'b0, rdr_valid}, 32'd0);
    chk("gi_no_flush", {31'b0, flush}, 32'd0);
    step();
    gwe = 1'b1;
    samp();
    chk("gi_ready", {31'b0, br_ready}, 32'd1);
    exp_q.push_back({1'b1, 16'h0300});
    step();
    br_valid = 1'b0;
    samp();
    expect_rdr("gi");
    chk("gi_flush", {31'b0, flush}, 32'd1);
    finish_flush("gi");

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
